// File: rtl/hazard_scoreboard_if.sv
// Interface: hazard_scoreboard_if
// Groups the ID-stage instruction fields, the halt request and the hazard
// controller's responses into one bundle.
//   master : datapath side, drives the ID fields and halt_req, observes controls
//   slave  : hazard_scoreboard side
// Signals:
//   id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wb, id_rd  ID instruction
//   halt_req                                                    debug stop level
//   pc_we, ifid_we, idex_bubble                                 issue control
//   fwd_a_sel, fwd_b_sel                                        EX operand selects
//   halt_ack, stall_cnt                                         status
interface hazard_scoreboard_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
);
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic                  id_use_rs;
    logic                  id_use_rt;
    logic                  id_wb;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  halt_req;
    logic                  pc_we;
    logic                  ifid_we;
    logic                  idex_bubble;
    logic [1:0]            fwd_a_sel;
    logic [1:0]            fwd_b_sel;
    logic                  halt_ack;
    logic [CNT_W-1:0]      stall_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wb, id_rd, halt_req,
        input  pc_we, ifid_we, idex_bubble, fwd_a_sel, fwd_b_sel, halt_ack, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wb, id_rd, halt_req,
        output pc_we, ifid_we, idex_bubble, fwd_a_sel, fwd_b_sel, halt_ack, stall_cnt
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Module: hazard_scoreboard
// Hazard controller for the 5-stage IF/ID/EX/MM/WB pipeline. Shadows the
// dest reg / WB flag of the in-flight EX, MM and WB instructions (plus EX
// sources), stalls ID on unresolved RAW hazards, drives the EX forwarding
// selects, runs the halt/drain sequence and counts hazard stall cycles.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    hazard_scoreboard_if.slave (ID fields, halt_req, controls, status)
module hazard_scoreboard #(
    parameter int REG_ADDR_W = 5,
    parameter int FWD_EN     = 1,
    parameter int RF_BYPASS  = 0,
    parameter int CNT_W      = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    hazard_scoreboard_if.slave  bus
);
    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    typedef struct packed {
        logic                  valid;
        logic                  wb;
        logic [REG_ADDR_W-1:0] rd;
        logic [REG_ADDR_W-1:0] rs;
        logic [REG_ADDR_W-1:0] rt;
    } stage_t;

    localparam logic [1:0] SEL_RF = 2'b00;
    localparam logic [1:0] SEL_MM = 2'b01;
    localparam logic [1:0] SEL_WB = 2'b10;

    // Without a write-through register file an instruction in WB is not yet
    // visible to a reader in ID.
    localparam bit WB_STALL = (RF_BYPASS == 0);

    state_t           state_q;
    stage_t           ex_q, mm_q, wb_q;
    stage_t           id_stage;
    logic [CNT_W-1:0] stall_cnt_q;
    logic             halt_ack_q;
    logic             hazard;
    logic             freeze;
    logic             hold;
    logic             pipe_empty;
    logic [1:0]       fwd_a, fwd_b;

    // Register 0 is hard-wired, so it never carries a dependency.
    function automatic logic match(input logic [REG_ADDR_W-1:0] s, input stage_t st);
        return st.valid && st.wb && (st.rd == s) && (s != '0);
    endfunction

    function automatic logic src_hazard(input logic [REG_ADDR_W-1:0] s,
                                        input stage_t ex, input stage_t mm, input stage_t wb);
        if (FWD_EN != 0)
            return match(s, wb) && WB_STALL;
        return match(s, ex) || match(s, mm) || (match(s, wb) && WB_STALL);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] s,
                                           input stage_t mm, input stage_t wb);
        if (FWD_EN == 0)   return SEL_RF;
        if (match(s, mm))  return SEL_MM;   // youngest result wins
        if (match(s, wb))  return SEL_WB;
        return SEL_RF;
    endfunction

    assign id_stage = '{valid: bus.id_valid, wb: bus.id_wb, rd: bus.id_rd,
                        rs: bus.id_rs, rt: bus.id_rt};

    assign pipe_empty = !ex_q.valid && !mm_q.valid && !wb_q.valid;

    // NOTE: every variable assigned in always_comb gets a default first so no
    // path leaves it unassigned, which would infer a latch.
    always_comb begin
        hazard = 1'b0;
        if (bus.id_valid) begin
            hazard = (bus.id_use_rs && src_hazard(bus.id_rs, ex_q, mm_q, wb_q)) ||
                     (bus.id_use_rt && src_hazard(bus.id_rt, ex_q, mm_q, wb_q));
        end
    end

    always_comb begin
        fwd_a = SEL_RF;
        fwd_b = SEL_RF;
        fwd_a = fwd_sel(ex_q.rs, mm_q, wb_q);
        fwd_b = fwd_sel(ex_q.rt, mm_q, wb_q);
    end

    // A halt request freezes issue in the same cycle it appears, ahead of any
    // hazard. rst_n gates the freeze so the pipe runs freely while held in
    // reset even if halt_req is already high.
    assign freeze = (state_q != RUN) || bus.halt_req;
    assign hold   = rst_n && (freeze || hazard);

    assign bus.pc_we       = !hold;
    assign bus.ifid_we     = !hold;
    assign bus.idex_bubble = hold;
    assign bus.fwd_a_sel   = fwd_a;
    assign bus.fwd_b_sel   = fwd_b;
    assign bus.halt_ack    = halt_ack_q;
    assign bus.stall_cnt   = stall_cnt_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values (MM<=EX and WB<=MM shift correctly).
    // NOTE: the shadow stages are reset because their valid bits decide
    // hazards; stale valid entries after reset would stall or forward wrongly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            ex_q        <= '0;
            mm_q        <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
            halt_ack_q  <= 1'b0;
        end else begin
            // The datapath's EX/MM and MM/WB registers have no enables.
            mm_q <= ex_q;
            wb_q <= mm_q;
            if (hold)
                ex_q.valid <= 1'b0;
            else
                ex_q <= id_stage;

            unique case (state_q)
                RUN: begin
                    if (bus.halt_req)
                        state_q <= DRAIN;
                    else if (hazard && (stall_cnt_q != '1))
                        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
                end
                DRAIN: begin
                    if (!bus.halt_req) begin
                        state_q <= RUN;
                    end else if (pipe_empty) begin
                        state_q    <= HALTED;
                        halt_ack_q <= 1'b1;
                    end
                end
                HALTED: begin
                    if (!bus.halt_req) begin
                        state_q    <= RUN;
                        halt_ack_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= RUN;
                    halt_ack_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Testbench: tb_hazard_scoreboard
// Drives four scoreboards with identical ID streams:
//   dut0 FWD_EN=1 RF_BYPASS=0, dut1 FWD_EN=0 RF_BYPASS=0,
//   dut2 FWD_EN=0 RF_BYPASS=1, dut3 FWD_EN=0 RF_BYPASS=0 with a 2-bit counter.
// A vector table covers the forwarding configuration cycle by cycle; directed
// sequences cover stall lengths, halt/drain, saturation and reset mid-stall.
module tb_hazard_scoreboard;
    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    hazard_scoreboard_if #(.REG_ADDR_W(5), .CNT_W(16)) bus0 ();
    hazard_scoreboard_if #(.REG_ADDR_W(5), .CNT_W(16)) bus1 ();
    hazard_scoreboard_if #(.REG_ADDR_W(5), .CNT_W(16)) bus2 ();
    hazard_scoreboard_if #(.REG_ADDR_W(5), .CNT_W(2))  bus3 ();

    hazard_scoreboard #(.REG_ADDR_W(5), .FWD_EN(1), .RF_BYPASS(0), .CNT_W(16))
        dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    hazard_scoreboard #(.REG_ADDR_W(5), .FWD_EN(0), .RF_BYPASS(0), .CNT_W(16))
        dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    hazard_scoreboard #(.REG_ADDR_W(5), .FWD_EN(0), .RF_BYPASS(1), .CNT_W(16))
        dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
    hazard_scoreboard #(.REG_ADDR_W(5), .FWD_EN(0), .RF_BYPASS(0), .CNT_W(2))
        dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [4:0] rs, rt, rd;
        logic       ur, ut, wb;
        logic       pc;
        logic [1:0] fa, fb;
        int         cnt;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic ur, input logic ut, input logic wb,
                          input logic [4:0] rd, input logic halt);
        bus0.id_valid = v; bus0.id_rs = rs; bus0.id_rt = rt; bus0.id_use_rs = ur;
        bus0.id_use_rt = ut; bus0.id_wb = wb; bus0.id_rd = rd; bus0.halt_req = halt;
        bus1.id_valid = v; bus1.id_rs = rs; bus1.id_rt = rt; bus1.id_use_rs = ur;
        bus1.id_use_rt = ut; bus1.id_wb = wb; bus1.id_rd = rd; bus1.halt_req = halt;
        bus2.id_valid = v; bus2.id_rs = rs; bus2.id_rt = rt; bus2.id_use_rs = ur;
        bus2.id_use_rt = ut; bus2.id_wb = wb; bus2.id_rd = rd; bus2.halt_req = halt;
        bus3.id_valid = v; bus3.id_rs = rs; bus3.id_rt = rt; bus3.id_use_rs = ur;
        bus3.id_use_rt = ut; bus3.id_wb = wb; bus3.id_rd = rd; bus3.halt_req = halt;
    endtask

    // Full-use, write-back instruction rd = rs op rt.
    task automatic issue(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic halt);
        set_id(1'b1, rs, rt, 1'b1, 1'b1, 1'b1, rd, halt);
    endtask

    task automatic idle();
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled
    // on the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                                input logic ur, input logic ut, input logic wb,
                                input logic [4:0] rd, input logic pc,
                                input logic [1:0] fa, input logic [1:0] fb, input int cnt);
        vec_t r;
        r.v = v; r.rs = rs; r.rt = rt; r.ur = ur; r.ut = ut; r.wb = wb; r.rd = rd;
        r.pc = pc; r.fa = fa; r.fb = fb; r.cnt = cnt;
        return r;
    endfunction

    initial begin
        // FWD_EN=1, RF_BYPASS=0 stream (dut0), one row per clock cycle.
        vecs[0]  = mk(1,  1,  2, 1, 1, 1,  3, 1, 2'b00, 2'b00, 0); // r3=r1+r2
        vecs[1]  = mk(1,  3,  1, 1, 1, 1,  4, 1, 2'b00, 2'b00, 0); // r4=r3+r1, no stall
        vecs[2]  = mk(1,  5,  6, 1, 1, 1,  7, 1, 2'b01, 2'b00, 0); // EX r3 from MM
        vecs[3]  = mk(1,  4,  8, 1, 1, 1,  9, 1, 2'b00, 2'b00, 0); // reads r4 two later
        vecs[4]  = mk(1, 10, 11, 1, 1, 1,  0, 1, 2'b10, 2'b00, 0); // EX r4 from WB; writes r0
        vecs[5]  = mk(1,  0,  0, 1, 1, 1, 12, 1, 2'b00, 2'b00, 0); // reads r0
        vecs[6]  = mk(1, 13, 14, 1, 1, 1, 15, 1, 2'b00, 2'b00, 0); // r0 never forwarded
        vecs[7]  = mk(1,  1,  2, 1, 1, 1, 16, 1, 2'b00, 2'b00, 0);
        vecs[8]  = mk(1,  2,  1, 1, 1, 1, 17, 1, 2'b00, 2'b00, 0);
        vecs[9]  = mk(1, 15,  1, 1, 1, 1, 18, 0, 2'b00, 2'b00, 0); // r15 in WB -> stall
        vecs[10] = mk(1, 15,  1, 1, 1, 1, 18, 1, 2'b00, 2'b00, 1); // held instr issues
        vecs[11] = mk(0,  0,  0, 0, 0, 0,  0, 1, 2'b00, 2'b00, 1);
        vecs[12] = mk(0,  0,  0, 0, 0, 0,  0, 1, 2'b00, 2'b00, 1);
        vecs[13] = mk(0, 18, 18, 1, 1, 0,  0, 1, 2'b00, 2'b00, 1); // invalid ID, r18 in WB

        rst_n = 1'b0;
        idle();
        #12;
        check("reset pc_we",       bus0.pc_we, 1);
        check("reset ifid_we",     bus0.ifid_we, 1);
        check("reset idex_bubble", bus0.idex_bubble, 0);
        check("reset fwd_a",       bus0.fwd_a_sel, 0);
        check("reset fwd_b",       bus0.fwd_b_sel, 0);
        check("reset halt_ack",    bus0.halt_ack, 0);
        check("reset stall_cnt",   bus0.stall_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();

        // Table-driven forwarding configuration.
        for (int i = 0; i < 14; i++) begin
            set_id(vecs[i].v, vecs[i].rs, vecs[i].rt, vecs[i].ur, vecs[i].ut,
                   vecs[i].wb, vecs[i].rd, 1'b0);
            @(negedge clk);
            check($sformatf("v%0d pc_we", i),       bus0.pc_we, vecs[i].pc);
            check($sformatf("v%0d ifid_we", i),     bus0.ifid_we, vecs[i].pc);
            check($sformatf("v%0d idex_bubble", i), bus0.idex_bubble, !vecs[i].pc);
            check($sformatf("v%0d fwd_a", i),       bus0.fwd_a_sel, vecs[i].fa);
            check($sformatf("v%0d fwd_b", i),       bus0.fwd_b_sel, vecs[i].fb);
            check($sformatf("v%0d stall_cnt", i),   bus0.stall_cnt, vecs[i].cnt);
            check($sformatf("v%0d halt_ack", i),    bus0.halt_ack, 0);
            next_cycle();
        end

        // Back-to-back dependency without forwarding: 3 stalls, 2 with bypass.
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        next_cycle();
        issue(5'd1, 5'd2, 5'd3, 1'b0);
        next_cycle();
        issue(5'd3, 5'd5, 5'd6, 1'b0);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) begin
                check("a1 dut0 pc_we", bus0.pc_we, 1);
                check("a1 dut1 pc_we", bus1.pc_we, 0);
                check("a1 dut2 pc_we", bus2.pc_we, 0);
            end
            if (c == 2) begin
                check("a2 dut0 fwd_a", bus0.fwd_a_sel, 2'b01);
                check("a2 dut0 stall_cnt", bus0.stall_cnt, 0);
                check("a2 dut1 fwd_a", bus1.fwd_a_sel, 2'b00);
                check("a2 dut1 pc_we", bus1.pc_we, 0);
                check("a2 dut2 pc_we", bus2.pc_we, 0);
            end
            if (c == 3) begin
                check("a3 dut1 pc_we", bus1.pc_we, 0);
                check("a3 dut2 pc_we", bus2.pc_we, 1);
            end
            if (c == 4)
                check("a4 dut1 pc_we", bus1.pc_we, 1);
            next_cycle();
        end
        idle();
        repeat (3) next_cycle();
        @(negedge clk);
        check("nofwd stall_cnt",    bus1.stall_cnt, 3);
        check("bypass stall_cnt",   bus2.stall_cnt, 2);
        check("narrow stall_cnt",   bus3.stall_cnt, 3);
        next_cycle();

        // Halt during a stream; dut1 also sees a hazard in the halt cycle.
        issue(5'd1, 5'd2, 5'd3, 1'b0);
        @(negedge clk);
        check("b0 pc_we", bus0.pc_we, 1);
        next_cycle();
        issue(5'd3, 5'd5, 5'd6, 1'b1);
        @(negedge clk);
        check("b1 pc_we",       bus0.pc_we, 0);
        check("b1 idex_bubble", bus0.idex_bubble, 1);
        check("b1 halt_ack",    bus0.halt_ack, 0);
        check("b1 dut1 pc_we",  bus1.pc_we, 0);
        next_cycle();
        begin
            bit acked = 1'b0;
            for (int c = 0; c < 10 && !acked; c++) begin
                @(negedge clk);
                check($sformatf("drain%0d pc_we", c), bus0.pc_we, 0);
                acked = bus0.halt_ack;
                next_cycle();
            end
            if (!acked) begin
                n_checks++;
                n_errors++;
                $display("FAIL halt_ack timeout: got 0 expected 1 within 10 cycles");
            end
        end
        @(negedge clk);
        check("halted halt_ack",  bus0.halt_ack, 1);
        check("halted dut1 cnt",  bus1.stall_cnt, 3);
        next_cycle();
        issue(5'd3, 5'd5, 5'd6, 1'b0);
        @(negedge clk);
        check("release pc_we still frozen", bus0.pc_we, 0);
        next_cycle();
        @(negedge clk);
        check("r0 pc_we",    bus0.pc_we, 1);
        check("r0 halt_ack", bus0.halt_ack, 0);
        next_cycle();
        issue(5'd6, 5'd1, 5'd7, 1'b0);
        @(negedge clk);
        check("r1 pc_we",       bus0.pc_we, 1);
        check("r1 dut3 pc_we",  bus3.pc_we, 0);
        next_cycle();
        idle();
        @(negedge clk);
        check("r2 fwd_a",          bus0.fwd_a_sel, 2'b01);
        check("r2 fwd_b",          bus0.fwd_b_sel, 2'b00);
        check("r2 dut3 saturated", bus3.stall_cnt, 3);
        next_cycle();

        // Asynchronous reset while dut1 is stalling.
        repeat (3) next_cycle();
        issue(5'd1, 5'd2, 5'd3, 1'b0);
        next_cycle();
        issue(5'd3, 5'd5, 5'd6, 1'b0);
        @(negedge clk);
        check("c1 dut1 pc_we before reset", bus1.pc_we, 0);
        #1;
        rst_n = 1'b0;
        #1;
        check("midstall rst pc_we",       bus1.pc_we, 1);
        check("midstall rst idex_bubble", bus1.idex_bubble, 0);
        check("midstall rst stall_cnt",   bus1.stall_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("after rst pc_we", bus1.pc_we, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
